// File: rtl/dds_sweep_ctrl.sv
// Chirp controller feeding dds_wrap: steps phase_inc_o from start_inc to stop_inc,
// holding each value for a programmable dwell, in single-shot or sawtooth mode.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 14,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [PHASE_WIDTH-1:0] start_inc_i,
  input  logic [PHASE_WIDTH-1:0] stop_inc_i,
  input  logic [PHASE_WIDTH-1:0] step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [PHASE_WIDTH-1:0] phase_inc_o,
  output logic                   en_o,
  output logic                   busy_o,
  output logic                   step_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] start_q, start_d;
  logic [PHASE_WIDTH-1:0] stop_q, stop_d;
  logic [PHASE_WIDTH-1:0] stepv_q, stepv_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   step_q, step_d;
  logic                   done_q, done_d;

  // One extra bit so the last step near the top of the range clamps instead of wrapping.
  logic [PHASE_WIDTH:0]   sum;
  logic                   dwell_end;
  logic                   at_stop;

  assign sum       = {1'b0, phase_q} + {1'b0, stepv_q};
  assign dwell_end = (cnt_q == dwell_q - DWELL_WIDTH'(1));
  assign at_stop   = (phase_q >= stop_q);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start_d = start_q;
    stop_d  = stop_q;
    stepv_d = stepv_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    en_d    = en_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start_i && !stop_i) begin
          start_d = start_inc_i;
          stop_d  = stop_inc_i;
          stepv_d = step_i;
          dwell_d = (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
          mode_d  = mode_i;
          phase_d = start_inc_i;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          step_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dwell_end) begin
          cnt_d = '0;
          if (at_stop && !mode_q) begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (at_stop) begin
            phase_d = start_q;
            step_d  = 1'b1;
          end else begin
            phase_d = (sum >= {1'b0, stop_q}) ? stop_q : sum[PHASE_WIDTH-1:0];
            step_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_WIDTH'(1);
        end
      end
      S_DONE: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      stepv_q <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      stepv_q <= stepv_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign phase_inc_o = phase_q;
  assign en_o        = en_q;
  assign busy_o      = busy_q;
  assign step_o      = step_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps push expected step/done events,
// a negedge monitor pops and checks them against the DUT strobes.
module tb_dds_sweep_ctrl;
  localparam int PW = 14;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0, stop_i = 1'b0, mode_i = 1'b0;
  logic [PW-1:0] start_inc_i = '0, stop_inc_i = '0, step_i = '0;
  logic [DW-1:0] dwell_i = '0;
  logic [PW-1:0] phase_inc_o;
  logic          en_o, busy_o, step_o, done_o;

  dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
    .start_inc_i(start_inc_i), .stop_inc_i(stop_inc_i), .step_i(step_i), .dwell_i(dwell_i),
    .phase_inc_o(phase_inc_o), .en_o(en_o), .busy_o(busy_o), .step_o(step_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit done;
    int phase;
  } ev_t;
  ev_t q[$];

  int total = 0;
  int bad = 0;

  function automatic void chk(bit ok, string name, string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  // Monitor: every step/done strobe must match the next expected event.
  always @(negedge clk_i) begin : monitor
    ev_t e;
    if (rstn_i && (step_o || done_o)) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected", $sformatf("cyc=%0d step=%0b done=%0b phase=%0d, none expected",
            cyc, step_o, done_o, phase_inc_o));
      end else begin
        e = q.pop_front();
        chk(cyc == e.cyc && int'(phase_inc_o) == e.phase && done_o == e.done &&
            step_o == !e.done && en_o == !e.done && busy_o == !e.done, "event",
            $sformatf("got cyc=%0d ph=%0d st=%0b dn=%0b en=%0b bz=%0b want cyc=%0d ph=%0d dn=%0b",
            cyc, phase_inc_o, step_o, done_o, en_o, busy_o, e.cyc, e.phase, e.done));
      end
    end
  end

  task automatic push(input int c, input bit d, input int p);
    ev_t e;
    e.cyc = c; e.done = d; e.phase = p;
    q.push_back(e);
  endtask

  // Drives a start request; t0 is the cycle in which the first value appears.
  task automatic kick(input bit m, input int s, input int e, input int st, input int dw,
                      output int t0);
    @(negedge clk_i);
    mode_i = m; start_inc_i = PW'(s); stop_inc_i = PW'(e); step_i = PW'(st);
    dwell_i = DW'(dw); start_i = 1'b1; stop_i = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      start_i = 1'b0; stop_i = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) begin
      @(negedge clk_i);
      #1;
      start_i = 1'b0; stop_i = 1'b0;
    end
    chk(q.size() == 0, name, $sformatf("%0d events still pending, want 0", q.size()));
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk_i);
  endtask

  initial begin
    int t0;
    #1;
    chk(phase_inc_o == 0 && !en_o && !busy_o && !step_o && !done_o, "reset",
        $sformatf("ph=%0d en=%0b bz=%0b st=%0b dn=%0b want all 0",
        phase_inc_o, en_o, busy_o, step_o, done_o));
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    idle(2);

    // single sweep, exact landing on stop
    kick(0, 100, 130, 10, 4, t0);
    push(t0, 0, 100); push(t0 + 4, 0, 110); push(t0 + 8, 0, 120); push(t0 + 12, 0, 130);
    push(t0 + 16, 1, 130);
    idle(1);
    wait_until(t0 + 8);
    #1;
    chk(busy_o && en_o, "busy_mid", $sformatf("bz=%0b en=%0b want 1 1", busy_o, en_o));
    drain("single", 40);
    idle(1);
    chk(!busy_o && !en_o && !done_o, "after_done",
        $sformatf("bz=%0b en=%0b dn=%0b want 0 0 0", busy_o, en_o, done_o));
    idle(2);

    // clamp to stop
    kick(0, 100, 125, 10, 4, t0);
    push(t0, 0, 100); push(t0 + 4, 0, 110); push(t0 + 8, 0, 120); push(t0 + 12, 0, 125);
    push(t0 + 16, 1, 125);
    idle(1);
    drain("clamp", 40);
    idle(3);

    // top of range, no wrap
    kick(0, 16380, 16383, 2, 1, t0);
    push(t0, 0, 16380); push(t0 + 1, 0, 16382); push(t0 + 2, 0, 16383); push(t0 + 3, 1, 16383);
    idle(1);
    drain("top", 20);
    idle(3);

    // continuous sawtooth, then abort
    kick(1, 100, 120, 10, 2, t0);
    push(t0, 0, 100); push(t0 + 2, 0, 110); push(t0 + 4, 0, 120);
    push(t0 + 6, 0, 100); push(t0 + 8, 0, 110); push(t0 + 10, 0, 120); push(t0 + 12, 0, 100);
    idle(1);
    wait_until(t0 + 12);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    #1;
    chk(!en_o && !busy_o && !done_o && phase_inc_o == 100, "abort",
        $sformatf("en=%0b bz=%0b dn=%0b ph=%0d want 0 0 0 100", en_o, busy_o, done_o, phase_inc_o));
    chk(q.size() == 0, "cont_events", $sformatf("%0d pending, want 0", q.size()));
    idle(4);

    // dwell 0 acts as 1; start during RUN ignored
    kick(0, 10, 13, 1, 0, t0);
    push(t0, 0, 10); push(t0 + 1, 0, 11); push(t0 + 2, 0, 12); push(t0 + 3, 0, 13);
    push(t0 + 4, 1, 13);
    @(negedge clk_i);
    start_inc_i = PW'(500); stop_inc_i = PW'(600); start_i = 1'b1;
    drain("dwell0", 20);
    idle(2);

    // start and stop together in IDLE stay idle
    @(negedge clk_i);
    start_inc_i = PW'(200); stop_inc_i = PW'(300); step_i = PW'(5); dwell_i = DW'(1);
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0;
    #1;
    chk(!busy_o && !en_o && !step_o, "start_stop",
        $sformatf("bz=%0b en=%0b st=%0b want 0 0 0", busy_o, en_o, step_o));
    idle(2);

    // asynchronous reset mid-run, then restart
    kick(0, 100, 130, 10, 4, t0);
    push(t0, 0, 100); push(t0 + 4, 0, 110);
    idle(1);
    wait_until(t0 + 5);
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    chk(phase_inc_o == 0 && !en_o && !busy_o && !step_o && !done_o, "async_rst",
        $sformatf("ph=%0d en=%0b bz=%0b st=%0b dn=%0b want all 0",
        phase_inc_o, en_o, busy_o, step_o, done_o));
    chk(q.size() == 0, "pre_rst_events", $sformatf("%0d pending, want 0", q.size()));
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle(3);
    chk(!busy_o && !en_o, "idle_after_rst", $sformatf("bz=%0b en=%0b want 0 0", busy_o, en_o));
    kick(0, 100, 110, 10, 1, t0);
    push(t0, 0, 100); push(t0 + 1, 0, 110); push(t0 + 2, 1, 110);
    idle(1);
    drain("restart", 20);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
